// File: rtl/dtrig_pipe.sv
// Delay-line pipeline with per-stage valid, selectable tap and a running
// occupancy count; en freezes the whole line, flush/rst empty it.
module dtrig_pipe #(
    parameter int                WIDTH   = 4,
    parameter int                DEPTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    localparam int               TSW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int               CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [TSW-1:0]   tap_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid,
    output logic [CW-1:0]    fill_cnt,
    output logic             full
);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [CW-1:0]    r_fill;

    logic [WIDTH-1:0] w_tap_q;
    logic             w_tap_vld;

    // Data is cleared along with the valids so q reads RST_VAL when empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RST_VAL;
            end
            r_vld  <= '0;
            r_fill <= '0;
        end else if (en) begin
            r_data[0] <= d;
            r_vld[0]  <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i] <= r_data[i-1];
                r_vld[i]  <= r_vld[i-1];
            end
            // Entering and leaving valids cancel when full, so no clamp is needed.
            r_fill <= r_fill + CW'(d_valid) - CW'(r_vld[DEPTH-1]);
        end
    end

    always_comb begin
        w_tap_q   = RST_VAL;
        w_tap_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TSW'(i)) begin
                w_tap_q   = r_data[i];
                w_tap_vld = r_vld[i];
            end
        end
    end

    assign q         = r_data[DEPTH-1];
    assign q_valid   = r_vld[DEPTH-1];
    assign tap_q     = w_tap_q;
    assign tap_valid = w_tap_vld;
    assign fill_cnt  = r_fill;
    assign full      = (r_fill == CW'(DEPTH));

endmodule

// File: tb/tb_dtrig_pipe.sv
// Directed bench for dtrig_pipe: a vector table on a DEPTH=4 instance plus
// short hand sequences on DEPTH=3 and DEPTH=1 instances.
module tb_dtrig_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic       rst, en, flush, dv;
    logic [3:0] d;
    logic [1:0] tap;
    logic [3:0] q, tq;
    logic       qv, tv, full;
    logic [2:0] fill;

    dtrig_pipe #(.WIDTH(4), .DEPTH(4), .RST_VAL(4'd0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(dv),
        .tap_sel(tap), .q(q), .q_valid(qv), .tap_q(tq), .tap_valid(tv),
        .fill_cnt(fill), .full(full)
    );

    // DEPTH=3 and DEPTH=1 instances share stimulus
    logic       rst3, en3, dv3;
    logic [3:0] d3;
    logic [1:0] tap3;
    logic       tap1;
    logic [3:0] q3, tq3, q1, tq1;
    logic       qv3, tv3, full3, qv1, tv1, full1;
    logic [1:0] fill3;
    logic       fill1;

    dtrig_pipe #(.WIDTH(4), .DEPTH(3), .RST_VAL(4'd0)) u_d3 (
        .clk(clk), .rst(rst3), .en(en3), .flush(1'b0), .d(d3), .d_valid(dv3),
        .tap_sel(tap3), .q(q3), .q_valid(qv3), .tap_q(tq3), .tap_valid(tv3),
        .fill_cnt(fill3), .full(full3)
    );

    dtrig_pipe #(.WIDTH(4), .DEPTH(1), .RST_VAL(4'd0)) u_d1 (
        .clk(clk), .rst(rst3), .en(en3), .flush(1'b0), .d(d3), .d_valid(dv3),
        .tap_sel(tap1), .q(q1), .q_valid(qv1), .tap_q(tq1), .tap_valid(tv1),
        .fill_cnt(fill1), .full(full1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst, en, flush, dv;
        logic [3:0] d;
        logic [1:0] tap;
        logic [3:0] q;
        logic       qv;
        logic [3:0] tq;
        logic       tv;
        logic [2:0] fill;
        logic       full;
    } vec_t;

    vec_t tbl [19];

    initial begin
        //            rst en fl dv  d      tap    q      qv tq     tv fill   full
        tbl[0]  = '{1'b0,1'b1,1'b0,1'b1, 4'd1, 2'd0, 4'd0, 1'b0, 4'd1, 1'b1, 3'd1, 1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b0,1'b1, 4'd2, 2'd1, 4'd0, 1'b0, 4'd1, 1'b1, 3'd2, 1'b0};
        tbl[2]  = '{1'b0,1'b1,1'b0,1'b1, 4'd3, 2'd2, 4'd0, 1'b0, 4'd1, 1'b1, 3'd3, 1'b0};
        tbl[3]  = '{1'b0,1'b1,1'b0,1'b1, 4'd4, 2'd3, 4'd1, 1'b1, 4'd1, 1'b1, 3'd4, 1'b1};
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b1, 4'd5, 2'd1, 4'd2, 1'b1, 4'd4, 1'b1, 3'd4, 1'b1};
        // stall: nothing moves
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b1, 4'd15,2'd0, 4'd2, 1'b1, 4'd5, 1'b1, 3'd4, 1'b1};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b1, 4'd14,2'd0, 4'd2, 1'b1, 4'd5, 1'b1, 3'd4, 1'b1};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b1, 4'd13,2'd0, 4'd2, 1'b1, 4'd5, 1'b1, 3'd4, 1'b1};
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b1, 4'd6, 2'd3, 4'd3, 1'b1, 4'd3, 1'b1, 3'd4, 1'b1};
        tbl[9]  = '{1'b0,1'b1,1'b0,1'b1, 4'd7, 2'd2, 4'd4, 1'b1, 4'd5, 1'b1, 3'd4, 1'b1};
        // flush beats en with a valid word
        tbl[10] = '{1'b0,1'b1,1'b1,1'b1, 4'd9, 2'd0, 4'd0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0};
        // alternating valid on an empty pipe
        tbl[11] = '{1'b0,1'b1,1'b0,1'b1, 4'd10,2'd0, 4'd0, 1'b0, 4'd10,1'b1, 3'd1, 1'b0};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b0, 4'd11,2'd0, 4'd0, 1'b0, 4'd11,1'b0, 3'd1, 1'b0};
        tbl[13] = '{1'b0,1'b1,1'b0,1'b1, 4'd12,2'd1, 4'd0, 1'b0, 4'd11,1'b0, 3'd2, 1'b0};
        tbl[14] = '{1'b0,1'b1,1'b0,1'b0, 4'd13,2'd2, 4'd10,1'b1, 4'd11,1'b0, 3'd2, 1'b0};
        tbl[15] = '{1'b0,1'b1,1'b0,1'b1, 4'd14,2'd3, 4'd11,1'b0, 4'd11,1'b0, 3'd2, 1'b0};
        tbl[16] = '{1'b0,1'b1,1'b0,1'b0, 4'd15,2'd0, 4'd12,1'b1, 4'd15,1'b0, 3'd2, 1'b0};
        tbl[17] = '{1'b0,1'b1,1'b0,1'b1, 4'd1, 2'd1, 4'd13,1'b0, 4'd15,1'b0, 3'd2, 1'b0};
        // reset overrides en
        tbl[18] = '{1'b1,1'b1,1'b0,1'b1, 4'd7, 2'd0, 4'd0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0};

        rst = 1'b1; en = 1'b0; flush = 1'b0; dv = 1'b0; d = 4'd0; tap = 2'd0;
        rst3 = 1'b1; en3 = 1'b0; dv3 = 1'b0; d3 = 4'd0; tap3 = 2'd0; tap1 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst q", {4'd0, q}, 8'd0);
        chk("rst q_valid", {7'd0, qv}, 8'd0);
        chk("rst tap_valid", {7'd0, tv}, 8'd0);
        chk("rst fill_cnt", {5'd0, fill}, 8'd0);
        chk("rst full", {7'd0, full}, 8'd0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; en = tbl[i].en; flush = tbl[i].flush;
            dv = tbl[i].dv; d = tbl[i].d; tap = tbl[i].tap;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d q", i), {4'd0, q}, {4'd0, tbl[i].q});
            chk($sformatf("v%0d q_valid", i), {7'd0, qv}, {7'd0, tbl[i].qv});
            chk($sformatf("v%0d tap_q", i), {4'd0, tq}, {4'd0, tbl[i].tq});
            chk($sformatf("v%0d tap_valid", i), {7'd0, tv}, {7'd0, tbl[i].tv});
            chk($sformatf("v%0d fill_cnt", i), {5'd0, fill}, {5'd0, tbl[i].fill});
            chk($sformatf("v%0d full", i), {7'd0, full}, {7'd0, tbl[i].full});
        end

        // DEPTH=3 / DEPTH=1 sequence
        @(negedge clk);
        rst3 = 1'b0; en3 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            d3 = 4'(k); dv3 = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("d3 e%0d fill", k), {6'd0, fill3}, 8'(k));
            chk($sformatf("d1 e%0d q", k), {4'd0, q1}, 8'(k));
            chk($sformatf("d1 e%0d fill", k), {7'd0, fill1}, 8'd1);
            chk($sformatf("d1 e%0d full", k), {7'd0, full1}, 8'd1);
            @(negedge clk);
        end
        en3 = 1'b0;
        chk("d3 q", {4'd0, q3}, 8'd1);
        chk("d3 q_valid", {7'd0, qv3}, 8'd1);
        chk("d3 full", {7'd0, full3}, 8'd1);
        tap3 = 2'd3; tap1 = 1'b1;
        #1;
        chk("d3 tap3 q", {4'd0, tq3}, 8'd0);
        chk("d3 tap3 valid", {7'd0, tv3}, 8'd0);
        chk("d1 tap1 q", {4'd0, tq1}, 8'd0);
        chk("d1 tap1 valid", {7'd0, tv1}, 8'd0);
        tap3 = 2'd2; tap1 = 1'b0;
        #1;
        chk("d3 tap2 q", {4'd0, tq3}, 8'd1);
        chk("d3 tap2 valid", {7'd0, tv3}, 8'd1);
        chk("d1 tap0 q", {4'd0, tq1}, 8'd3);
        chk("d1 tap0 valid", {7'd0, tv1}, 8'd1);

        @(negedge clk);
        en3 = 1'b1; d3 = 4'd4; dv3 = 1'b0;
        @(posedge clk);
        #1;
        chk("d3 e4 q", {4'd0, q3}, 8'd2);
        chk("d3 e4 fill", {6'd0, fill3}, 8'd2);
        chk("d3 e4 full", {7'd0, full3}, 8'd0);
        chk("d1 e4 q", {4'd0, q1}, 8'd4);
        chk("d1 e4 q_valid", {7'd0, qv1}, 8'd0);
        chk("d1 e4 fill", {7'd0, fill1}, 8'd0);
        chk("d1 e4 full", {7'd0, full1}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
